// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared types and constants for the multiply/divide unit
package mult_div_pkg;

  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } md_state_t;

  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = 6;

endpackage

// File: rtl/md_step.sv
// rtl/md_step.sv - one combinational iteration: Booth add/sub + shift, or restoring divide step
module md_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_t             i_mode,
  input  logic [2*WIDTH-1:0] i_sr,
  input  logic               i_q_m1,
  input  logic [WIDTH-1:0]   i_m,
  output logic [2*WIDTH-1:0] o_sr,
  output logic               o_q_m1
);

  logic [WIDTH:0] w_opa;
  logic [WIDTH:0] w_opb;
  logic [WIDTH:0] w_res;
  logic           w_sub;

  // The single WIDTH+1 adder/subtractor is shared by both modes.
  assign w_res = w_sub ? (w_opa - w_opb) : (w_opa + w_opb);

  always_comb begin
    w_opa  = '0;
    w_opb  = '0;
    w_sub  = 1'b0;
    o_sr   = i_sr;
    o_q_m1 = 1'b0;
    if (i_mode == MD_MULT) begin
      w_opa = {i_sr[2*WIDTH-1], i_sr[2*WIDTH-1:WIDTH]};
      case ({i_sr[0], i_q_m1})
        2'b01:   w_opb = {i_m[WIDTH-1], i_m};
        2'b10: begin
          w_opb = {i_m[WIDTH-1], i_m};
          w_sub = 1'b1;
        end
        default: w_opb = '0;
      endcase
      o_sr   = {w_res[WIDTH:1], w_res[0], i_sr[WIDTH-1:1]};
      o_q_m1 = i_sr[0];
    end else begin
      // Shifted remainder needs WIDTH+1 bits since the divisor magnitude can reach 2^(WIDTH-1).
      w_opa = i_sr[2*WIDTH-1:WIDTH-1];
      w_opb = {1'b0, i_m};
      w_sub = 1'b1;
      if (!w_res[WIDTH]) begin
        o_sr = {w_res[WIDTH-1:0], i_sr[WIDTH-2:0], 1'b1};
      end else begin
        o_sr = {w_opa[WIDTH-1:0], i_sr[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed Booth multiply / restoring divide with HI/LO results
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  md_state_t             r_state;
  md_state_t             w_next;
  logic [MD_CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0]    r_sr;
  logic                  r_q_m1;
  logic [WIDTH-1:0]      r_m;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [WIDTH-1:0]      r_hi;
  logic [WIDTH-1:0]      r_lo;
  logic                  r_div_zero;

  logic                  w_div0;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_running;
  md_op_t                w_mode;
  logic [2*WIDTH-1:0]    w_step_sr;
  logic                  w_step_q_m1;
  logic [WIDTH-1:0]      w_a_mag;
  logic [WIDTH-1:0]      w_b_mag;
  logic [WIDTH-1:0]      w_quot;
  logic [WIDTH-1:0]      w_rem;

  assign w_div0    = (r_state == IDLE) && start && (op == MD_DIV) && (b == '0);
  assign w_accept  = (r_state == IDLE) && start && !w_div0;
  assign w_last    = (r_cnt == MD_CNT_W'(MD_ITER - 1));
  assign w_running = (r_state == MULT) || (r_state == DIV);
  assign w_mode    = (r_state == DIV) ? MD_DIV : MD_MULT;
  assign w_a_mag   = a[WIDTH-1] ? -a : a;
  assign w_b_mag   = b[WIDTH-1] ? -b : b;
  assign w_quot    = r_neg_q ? -w_step_sr[WIDTH-1:0] : w_step_sr[WIDTH-1:0];
  assign w_rem     = r_neg_r ? -w_step_sr[2*WIDTH-1:WIDTH] : w_step_sr[2*WIDTH-1:WIDTH];

  md_step #(.WIDTH(WIDTH)) u_step (
    .i_mode (w_mode),
    .i_sr   (r_sr),
    .i_q_m1 (r_q_m1),
    .i_m    (r_m),
    .o_sr   (w_step_sr),
    .o_q_m1 (w_step_q_m1)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_div0)        w_next = FIN;
        else if (w_accept) w_next = (op == MD_DIV) ? DIV : MULT;
      end
      MULT:    if (w_last) w_next = FIN;
      DIV:     if (w_last) w_next = FIN;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = w_running;
    done = (r_state == FIN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_sr       <= '0;
      r_q_m1     <= 1'b0;
      r_m        <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_q_m1     <= 1'b0;
      r_div_zero <= 1'b0;
      // Booth: multiplier in the low half, multiplicand held aside; divide works on magnitudes.
      if (op == MD_MULT) begin
        r_sr <= {{WIDTH{1'b0}}, b};
        r_m  <= a;
      end else begin
        r_sr    <= {{WIDTH{1'b0}}, w_a_mag};
        r_m     <= w_b_mag;
        r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
        r_neg_r <= a[WIDTH-1];
      end
    end else if (w_div0) begin
      r_div_zero <= 1'b1;
    end else if (w_running) begin
      r_sr   <= w_step_sr;
      r_q_m1 <= w_step_q_m1;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        if (r_state == MULT) begin
          r_hi <= w_step_sr[2*WIDTH-1:WIDTH];
          r_lo <= w_step_sr[WIDTH-1:0];
        end else begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end
      end
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
  import mult_div_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  md_op_t      op = MD_MULT;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  task automatic start_op(input md_op_t o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'hDEADBEEF;
    b     = 32'hDEADBEEF;
  endtask

  task automatic wait_done(output int n, output int busy_n, output logic busy_at_done);
    n = 0;
    busy_n = 0;
    busy_at_done = 1'b0;
    while (n <= 40) begin
      @(negedge clk);
      if (done) begin
        busy_at_done = busy;
        break;
      end
      n++;
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (hi !== 32'h0)   begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0)   begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
    reset = 1'b1;
  endtask

  task automatic test_mult_timing();
    int n, bn;
    logic bd;
    start_op(MD_MULT, 32'd7, 32'hFFFFFFFD);
    wait_done(n, bn, bd);
    checks++; if (n !== 32)  begin errors++; $display("FAIL mult_latency: got %0d expected 32", n); end
    checks++; if (bn !== 32) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 32", bn); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL mult_busy_with_done: got %b expected 0", bd); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_7x-3_hi: got %h expected ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_7x-3_lo: got %h expected ffffffeb", lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo_hold: got %h expected ffffffeb", lo); end
  endtask

  task automatic test_mult_vectors();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] eh [3];
    logic [31:0] el [3];
    int n, bn;
    logic bd;
    va[0] = 32'h80000000; vb[0] = 32'h80000000; eh[0] = 32'h40000000; el[0] = 32'h00000000;
    va[1] = 32'hFFFFFF9C; vb[1] = 32'hFFFFFF9C; eh[1] = 32'h00000000; el[1] = 32'h00002710;
    va[2] = 32'h80000000; vb[2] = 32'h00000003; eh[2] = 32'hFFFFFFFE; el[2] = 32'h80000000;
    for (int i = 0; i < 3; i++) begin
      start_op(MD_MULT, va[i], vb[i]);
      wait_done(n, bn, bd);
      checks++; if (n !== 32) begin errors++; $display("FAIL mult_vec%0d_latency: got %0d expected 32", i, n); end
      checks++; if (hi !== eh[i]) begin errors++; $display("FAIL mult_vec%0d_hi: got %h expected %h", i, hi, eh[i]); end
      checks++; if (lo !== el[i]) begin errors++; $display("FAIL mult_vec%0d_lo: got %h expected %h", i, lo, el[i]); end
    end
  endtask

  task automatic test_div_vectors();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] eh [4];
    logic [31:0] el [4];
    int n, bn;
    logic bd;
    va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;         eh[0] = 32'hFFFFFFFF; el[0] = 32'hFFFFFFFD;
    va[1] = 32'h80000000; vb[1] = 32'hFFFFFFFF; eh[1] = 32'h00000000; el[1] = 32'h80000000;
    va[2] = 32'd100;      vb[2] = 32'd7;         eh[2] = 32'd2;        el[2] = 32'd14;
    va[3] = 32'd7;        vb[3] = 32'hFFFFFFFE; eh[3] = 32'd1;        el[3] = 32'hFFFFFFFD;
    for (int i = 0; i < 4; i++) begin
      start_op(MD_DIV, va[i], vb[i]);
      wait_done(n, bn, bd);
      checks++; if (n !== 32) begin errors++; $display("FAIL div_vec%0d_latency: got %0d expected 32", i, n); end
      checks++; if (hi !== eh[i]) begin errors++; $display("FAIL div_vec%0d_hi: got %h expected %h", i, hi, eh[i]); end
      checks++; if (lo !== el[i]) begin errors++; $display("FAIL div_vec%0d_lo: got %h expected %h", i, lo, el[i]); end
      checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_vec%0d_div_zero: got %b expected 0", i, div_zero); end
    end
  endtask

  task automatic test_div_zero();
    int n, bn;
    logic bd;
    start_op(MD_MULT, 32'd124692599, 32'd620);
    wait_done(n, bn, bd);
    checks++; if (hi !== 32'h12) begin errors++; $display("FAIL dz_preload_hi: got %h expected 12", hi); end
    checks++; if (lo !== 32'h34) begin errors++; $display("FAIL dz_preload_lo: got %h expected 34", lo); end
    start_op(MD_DIV, 32'd5, 32'd0);
    wait_done(n, bn, bd);
    checks++; if (n !== 0) begin errors++; $display("FAIL dz_latency: got %0d expected 0", n); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL dz_busy: got %b expected 0", bd); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", div_zero); end
    checks++; if (hi !== 32'h12) begin errors++; $display("FAIL dz_hi_hold: got %h expected 12", hi); end
    checks++; if (lo !== 32'h34) begin errors++; $display("FAIL dz_lo_hold: got %h expected 34", lo); end
    @(negedge clk);
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_sticky: got %b expected 1", div_zero); end
    start_op(MD_MULT, 32'd3, 32'd4);
    wait_done(n, bn, bd);
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b expected 0", div_zero); end
    checks++; if (lo !== 32'd12) begin errors++; $display("FAIL dz_next_lo: got %h expected c", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL dz_next_hi: got %h expected 0", hi); end
  endtask

  task automatic test_ignore_start();
    int n;
    start_op(MD_MULT, 32'd6, 32'd7);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 5 || i == 20) begin
        start = 1'b1;
        op    = MD_DIV;
        a     = 32'd100;
        b     = 32'd0;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      n++;
    end
    start = 1'b0;
    checks++; if (n !== 32) begin errors++; $display("FAIL ignore_latency: got %0d expected 32", n); end
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL ignore_lo: got %h expected 2a", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL ignore_hi: got %h expected 0", hi); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL ignore_div_zero: got %b expected 0", div_zero); end
  endtask

  task automatic test_reset_mid_op();
    int n, bn;
    logic bd;
    start_op(MD_DIV, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h expected 0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b expected 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL rst_mid_div_zero: got %b expected 0", div_zero); end
    start_op(MD_MULT, 32'd2, 32'd3);
    wait_done(n, bn, bd);
    checks++; if (n !== 32) begin errors++; $display("FAIL rst_mid_next_latency: got %0d expected 32", n); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL rst_mid_next_lo: got %h expected 6", lo); end
  endtask

  task automatic test_back_to_back();
    int n, bn;
    logic bd;
    start_op(MD_DIV, 32'hFFFFFF9C, 32'd9);
    wait_done(n, bn, bd);
    checks++; if (lo !== 32'hFFFFFFF5) begin errors++; $display("FAIL b2b_div_lo: got %h expected fffffff5", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_div_hi: got %h expected ffffffff", hi); end
    start_op(MD_MULT, 32'h00010000, 32'h00010000);
    wait_done(n, bn, bd);
    checks++; if (n !== 32) begin errors++; $display("FAIL b2b_mult_latency: got %0d expected 32", n); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL b2b_mult_hi: got %h expected 1", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL b2b_mult_lo: got %h expected 0", lo); end
  endtask

  initial begin
    test_reset();
    test_mult_timing();
    test_mult_vectors();
    test_div_vectors();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
